// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 codes, engine states and burst legality check
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_1B = 3'b000;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Only single-byte beats are legal, and WRAP needs a power-of-two beat count.
    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic bad_wrap_len;
        bad_wrap_len = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (size != SIZE_1B) || (burst == BURST_RSVD) ||
               (burst == BURST_WRAP && bad_wrap_len);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// rtl/axi4_burst_addr_gen.sv - combinational next beat address for FIXED/INCR/WRAP bursts
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] len_i,
    input  logic [1:0]    burst_i,
    output logic [AW-1:0] next_addr_o
);

    always_comb begin
        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = addr_i + AW'(1);
            // The current address always sits inside the wrap window, so its upper bits are the boundary.
            BURST_WRAP: next_addr_o = (addr_i & ~len_i) | ((addr_i + AW'(1)) & len_i);
            default:    next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi4_bram_slave.sv
// rtl/axi4_bram_slave.sv - AXI4 slave with independent read/write engines over a block RAM
module axi4_bram_slave
    import axi4_pkg::*;
#(
    parameter int memWidth      = 8,
    parameter int memDepth      = 32,
    parameter int addressLength = 5
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [3:0]               AWID,
    input  logic [addressLength-1:0] AWADDR,
    input  logic [7:0]               AWLEN,
    input  logic [2:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [3:0]               WID,
    input  logic [memWidth-1:0]      WDATA,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [3:0]               BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [3:0]               ARID,
    input  logic [addressLength-1:0] ARADDR,
    input  logic [7:0]               ARLEN,
    input  logic [2:0]               ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [3:0]               RID,
    output logic [memWidth-1:0]      RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY
);

    localparam int AL = addressLength;

    logic [memWidth-1:0] mem [memDepth];

    // Bursts end on beat count alone.
    logic unused_wlast;
    assign unused_wlast = WLAST;

    w_state_e      w_state_q, w_state_d;
    logic [3:0]    awid_q, awid_d;
    logic [AL-1:0] waddr_q, waddr_d, waddr_next;
    logic [7:0]    wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]    wburst_q, wburst_d;
    logic          werr_q, werr_d;
    logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [3:0]    bid_q, bid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          mem_we;

    axi4_burst_addr_gen #(.AW(AL)) u_waddr_gen (
        .addr_i      (waddr_q),
        .len_i       (wlen_q[AL-1:0]),
        .burst_i     (wburst_q),
        .next_addr_o (waddr_next)
    );

    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (AWVALID && awready_q) begin
                awid_d    = AWID;
                waddr_d   = AWADDR;
                wlen_d    = AWLEN;
                wburst_d  = AWBURST;
                wcnt_d    = 8'd0;
                werr_d    = burst_err(AWSIZE, AWBURST, AWLEN);
                w_state_d = W_DATA;
            end
            W_DATA: if (WVALID && wready_q) begin
                if (werr_q || WID != awid_q) werr_d = 1'b1;
                else                         mem_we = 1'b1;
                waddr_d = waddr_next;
                wcnt_d  = wcnt_q + 8'd1;
                if (wcnt_q == wlen_q) w_state_d = W_RESP;
            end
            W_RESP: if (bvalid_q && BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bid_d     = bvalid_d ? awid_d : 4'd0;
        bresp_d   = (bvalid_d && werr_d) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we && !ARESET) mem[waddr_q] <= WDATA;
    end

    r_state_e      r_state_q, r_state_d;
    logic [3:0]    arid_q, arid_d;
    logic [AL-1:0] raddr_q, raddr_d, raddr_next;
    logic [7:0]    rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]    rburst_q, rburst_d;
    logic          rerr_q, rerr_d, rload;
    logic          arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [3:0]    rid_q, rid_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [memWidth-1:0] rdata_q;

    axi4_burst_addr_gen #(.AW(AL)) u_raddr_gen (
        .addr_i      (raddr_q),
        .len_i       (rlen_q[AL-1:0]),
        .burst_i     (rburst_q),
        .next_addr_o (raddr_next)
    );

    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rerr_d    = rerr_q;
        rload     = 1'b0;
        case (r_state_q)
            R_IDLE: if (ARVALID && arready_q) begin
                arid_d    = ARID;
                raddr_d   = ARADDR;
                rlen_d    = ARLEN;
                rburst_d  = ARBURST;
                rcnt_d    = 8'd0;
                rerr_d    = burst_err(ARSIZE, ARBURST, ARLEN);
                rload     = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: if (rvalid_q && RREADY) begin
                if (rcnt_q == rlen_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    raddr_d = raddr_next;
                    rcnt_d  = rcnt_q + 8'd1;
                    rload   = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rlast_d   = rvalid_d && (rcnt_d == rlen_d);
        rid_d     = rvalid_d ? arid_d : 4'd0;
        rresp_d   = (rvalid_d && rerr_d) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rerr_q    <= rerr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
        end
    end

    // Data is captured only when a beat is launched, so a stalled beat ignores later writes.
    always_ff @(posedge ACLK) begin
        if (ARESET || !rvalid_d) rdata_q <= '0;
        else if (rload)          rdata_q <= rerr_d ? '0 : mem[raddr_d];
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi4_bram_slave.sv
// tb/tb_axi4_bram_slave.sv - directed table-driven bench for axi4_bram_slave
module tb_axi4_bram_slave;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic [3:0] AWID, WID, BID, ARID, RID;
    logic [4:0] AWADDR, ARADDR;
    logic [7:0] AWLEN, ARLEN, WDATA, RDATA;
    logic [2:0] AWSIZE, ARSIZE;
    logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
    logic       AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic       ARVALID, ARREADY, RLAST, RVALID, RREADY;

    axi4_bram_slave #(.memWidth(8), .memDepth(32), .addressLength(5)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic            is_wr;
        logic [3:0]      id;
        logic [4:0]      addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic [2:0]      bad;    // write beat sent with a wrong WID, 7 = none
        logic [3:0][7:0] data;   // write data or expected read data, beat 0 in data[0]
        logic [1:0]      resp;
        logic [7:0]      rpat;   // RREADY per read cycle, bit 0 first
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic w, input logic [3:0] id, input logic [4:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst, input logic [2:0] bad,
                                 input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] d3,
                                 input logic [1:0] resp, input logic [7:0] rpat);
        vec_t v;
        v.is_wr = w; v.id = id; v.addr = addr; v.len = len; v.size = size;
        v.burst = burst; v.bad = bad; v.resp = resp; v.rpat = rpat;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        return v;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input vec_t v);
        int n;
        AWID = v.id; AWADDR = v.addr; AWLEN = v.len; AWSIZE = v.size; AWBURST = v.burst;
        AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin tick(); n++; end
        check("awready", 32'(AWREADY), 32'd1);
        tick();
        AWVALID = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            WDATA  = v.data[b];
            WID    = (b == int'(v.bad)) ? (v.id ^ 4'hF) : v.id;
            WLAST  = (b == int'(v.len));
            WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin tick(); n++; end
            check("wready", 32'(WREADY), 32'd1);
            tick();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 50) begin tick(); n++; end
        check("bvalid", 32'(BVALID), 32'd1);
        check("bid", 32'(BID), 32'(v.id));
        check("bresp", 32'(BRESP), 32'(v.resp));
        tick();
        BREADY = 1'b0;
        check("b_done_awready", {30'd0, BVALID, AWREADY}, 32'd1);
    endtask

    task automatic do_read(input vec_t v);
        int n, beat, cyc;
        ARID = v.id; ARADDR = v.addr; ARLEN = v.len; ARSIZE = v.size; ARBURST = v.burst;
        ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin tick(); n++; end
        check("arready", 32'(ARREADY), 32'd1);
        tick();
        ARVALID = 1'b0;
        check("r_latency", 32'(RVALID), 32'd1);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(v.len) && cyc < 64) begin
            RREADY = (cyc < 8) ? v.rpat[cyc] : 1'b1;
            check("rvalid", 32'(RVALID), 32'd1);
            check("rdata", 32'(RDATA), 32'(v.data[beat]));
            check("rid", 32'(RID), 32'(v.id));
            check("rresp", 32'(RRESP), 32'(v.resp));
            check("rlast", 32'(RLAST), 32'(beat == int'(v.len)));
            tick();
            if (RREADY) beat++;
            cyc++;
        end
        RREADY = 1'b0;
        check("r_done_arready", {30'd0, RVALID, ARREADY}, 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RID, RDATA, RRESP, RLAST, RVALID},
              32'd0);
    endtask

    initial begin
        vecs[0]  = mkv(1, 0,  0,  3, 0, 2'b01, 7, 8'h04, 8'h07, 8'h06, 8'h05, 2'b00, 8'hFF);
        vecs[1]  = mkv(0, 1,  0,  3, 0, 2'b01, 7, 8'h04, 8'h07, 8'h06, 8'h05, 2'b00, 8'hFF);
        vecs[2]  = mkv(0, 2,  0,  3, 0, 2'b01, 7, 8'h04, 8'h07, 8'h06, 8'h05, 2'b00, 8'hF9);
        vecs[3]  = mkv(1, 3,  6,  3, 0, 2'b10, 7, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 2'b00, 8'hFF);
        vecs[4]  = mkv(0, 4,  4,  3, 0, 2'b01, 7, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 2'b00, 8'hFF);
        vecs[5]  = mkv(1, 5,  31, 1, 0, 2'b01, 7, 8'hB0, 8'hB1, 8'h00, 8'h00, 2'b00, 8'hFF);
        vecs[6]  = mkv(0, 6,  31, 1, 0, 2'b01, 7, 8'hB0, 8'hB1, 8'h00, 8'h00, 2'b00, 8'hFF);
        vecs[7]  = mkv(0, 7,  1,  0, 0, 2'b00, 7, 8'h07, 8'h00, 8'h00, 8'h00, 2'b00, 8'hFF);
        vecs[8]  = mkv(1, 8,  1,  1, 1, 2'b01, 7, 8'hEE, 8'hEF, 8'h00, 8'h00, 2'b10, 8'hFF);
        vecs[9]  = mkv(0, 9,  0,  3, 0, 2'b01, 7, 8'hB1, 8'h07, 8'h06, 8'h05, 2'b00, 8'hFF);
        vecs[10] = mkv(1, 10, 8,  2, 0, 2'b01, 7, 8'h11, 8'h12, 8'h13, 8'h00, 2'b00, 8'hFF);
        vecs[11] = mkv(1, 11, 8,  2, 0, 2'b01, 1, 8'hC0, 8'hC1, 8'hC2, 8'h00, 2'b10, 8'hFF);
        vecs[12] = mkv(0, 12, 8,  2, 0, 2'b01, 7, 8'hC0, 8'h12, 8'h13, 8'h00, 2'b00, 8'hFF);
        vecs[13] = mkv(0, 13, 0,  1, 0, 2'b11, 7, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 8'hFF);
        vecs[14] = mkv(1, 14, 12, 2, 0, 2'b00, 7, 8'h21, 8'h22, 8'h23, 8'h00, 2'b00, 8'hFF);
        vecs[15] = mkv(0, 15, 12, 0, 0, 2'b00, 7, 8'h23, 8'h00, 8'h00, 8'h00, 2'b00, 8'hFF);
        vecs[16] = mkv(0, 0,  5,  3, 0, 2'b10, 7, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 2'b00, 8'hFF);
        vecs[17] = mkv(0, 1,  0,  2, 0, 2'b10, 7, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 8'hFF);

        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        tick();
        tick();
        check_all_zero("reset_outputs");
        ARESET = 1'b0;
        tick();
        check("ready_after_reset", {30'd0, AWREADY, ARREADY}, 32'd3);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i]);
            else               do_read(vecs[i]);
        end

        // Reset two beats into a four-beat write, then a fresh burst over the tail.
        AWID = 4'd1; AWADDR = 5'd16; AWLEN = 8'd3; AWSIZE = 3'd0; AWBURST = 2'b01;
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        for (int b = 0; b < 2; b++) begin
            WID = 4'd1; WDATA = 8'h31 + 8'(b); WVALID = 1'b1;
            check("mid_wready", 32'(WREADY), 32'd1);
            tick();
        end
        WVALID = 1'b0;
        ARESET = 1'b1;
        tick();
        check_all_zero("midburst_reset_outputs");
        ARESET = 1'b0;
        tick();
        check("ready_after_midreset", {29'd0, AWREADY, ARREADY, WREADY}, 32'd6);
        do_write(mkv(1, 2, 18, 1, 0, 2'b01, 7, 8'h41, 8'h42, 8'h00, 8'h00, 2'b00, 8'hFF));
        do_read(mkv(0, 3, 16, 3, 0, 2'b01, 7, 8'h31, 8'h32, 8'h41, 8'h42, 2'b00, 8'hFF));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
